// File: rtl/tug_round_arbiter.sv
// tug_round_arbiter: Tug of War round sequencer; countdown, go lamp, first push moves the rope.
// Optional FALSE_START_EN: a push during the countdown awards the round to the opponent.
module tug_round_arbiter #(
  parameter int HALF      = 4,
  parameter int DELAY_CYC = 50,
  parameter int HOLD_CYC  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            lpush,
  input  logic            rpush,
  output logic [2*HALF:0] leds,
  output logic            go,
  output logic [1:0]      rndres,
  output logic [1:0]      winner,
  output logic            busy
);
  localparam int N  = 2*HALF+1;
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(DELAY_CYC > HOLD_CYC ? DELAY_CYC : HOLD_CYC) + 1;
  localparam logic [PW-1:0] MID = PW'(HALF);
  localparam logic [PW-1:0] TOP = PW'(2*HALF);
  localparam logic [CW-1:0] DLY = CW'(DELAY_CYC-1);
  localparam logic [CW-1:0] HLD = CW'(HOLD_CYC-1);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, ARMED, RESULT, DONE} state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [1:0]    rndres_q, rndres_d, winner_q, winner_d;
  logic [N-1:0]  leds_q, leds_d;
  logic          go_q, go_d, busy_q, busy_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pos_q    <= MID;
      rndres_q <= 2'b00;
      winner_q <= 2'b00;
      leds_q   <= N'(1) << HALF;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      rndres_q <= rndres_d;
      winner_q <= winner_d;
      leds_q   <= leds_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    rndres_d = rndres_q;
    winner_d = winner_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d  = COUNTDOWN;
        cnt_d    = DLY;
        pos_d    = MID;
        rndres_d = 2'b00;
        winner_d = 2'b00;
      end
      COUNTDOWN: begin
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? ARMED : COUNTDOWN;
`ifdef FALSE_START_EN
        // a jumped start hands the point to the other player
        if (lpush || rpush) begin
          state_d  = RESULT;
          cnt_d    = HLD;
          rndres_d = {lpush, rpush};
          pos_d    = (lpush && !rpush) ? pos_q + 1'b1 : (rpush && !lpush) ? pos_q - 1'b1 : pos_q;
        end
`endif
      end
      ARMED: if (lpush || rpush) begin
        state_d  = RESULT;
        cnt_d    = HLD;
        rndres_d = {rpush, lpush};
        pos_d    = (lpush && !rpush) ? pos_q - 1'b1 : (rpush && !lpush) ? pos_q + 1'b1 : pos_q;
      end
      RESULT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d  = (pos_q == '0 || pos_q == TOP) ? DONE : COUNTDOWN;
          cnt_d    = DLY;
          winner_d = (pos_q == '0) ? 2'b01 : (pos_q == TOP) ? 2'b10 : 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    leds_d = N'(1) << pos_d;
    go_d   = state_d == ARMED;
    busy_d = state_d inside {COUNTDOWN, ARMED, RESULT};
  end
  assign leds   = leds_q;
  assign go     = go_q;
  assign rndres = rndres_q;
  assign winner = winner_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_tug_round_arbiter.sv
// tb_tug_round_arbiter: random and directed games against a time-stamp based model of the round rules.
module tb_tug_round_arbiter;
  localparam int HALF = 4, DELAY = 50, HOLD = 20, N = 2*HALF+1;
  logic clk = 1'b0, rst, start, lpush, rpush;
  logic [N-1:0] leds;
  logic go, busy;
  logic [1:0] rndres, winner;
  int n_tests = 0, n_fail = 0;
  int e = 0;
  bit active, in_res;
  int go_at, res_end, pos, rnd, win;

  always #10 clk = ~clk;

  tug_round_arbiter #(.HALF(HALF), .DELAY_CYC(DELAY), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .lpush(lpush), .rpush(rpush),
    .leds(leds), .go(go), .rndres(rndres), .winner(winner), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, got, exp, e);
    end
  endtask

  function automatic bit m_armed();
    return active && !in_res && e >= go_at;
  endfunction

  // model keyed on edge numbers: go rises DELAY edges after a round starts, results last HOLD edges
  task automatic step(input bit r, input bit s, input bit l, input bit p);
    bit armed;
    armed = m_armed();
    e++;
    if (r) begin
      active = 0; in_res = 0; pos = HALF; rnd = 0; win = 0; go_at = 0;
    end else if (!active) begin
      if (s) begin
        active = 1; in_res = 0; go_at = e + DELAY; pos = HALF; rnd = 0; win = 0;
      end
    end else if (in_res) begin
      if (e == res_end) begin
        if (pos == 0) begin active = 0; win = 1; end
        else if (pos == 2*HALF) begin active = 0; win = 2; end
        else begin in_res = 0; go_at = e + DELAY; end
      end
    end else if (armed) begin
      if (l || p) begin
        in_res = 1; res_end = e + HOLD;
        pos = pos + int'(p) - int'(l);
        rnd = (p ? 2 : 0) + (l ? 1 : 0);
      end
    end
`ifdef FALSE_START_EN
    else if (l || p) begin
      in_res = 1; res_end = e + HOLD;
      pos = pos + int'(l) - int'(p);
      rnd = (l ? 2 : 0) + (p ? 1 : 0);
    end
`endif
  endtask

  task automatic cyc(input bit r, input bit s, input bit l, input bit p);
    @(negedge clk);
    rst = r; start = s; lpush = l; rpush = p;
    @(posedge clk);
    step(r, s, l, p);
    #1;
    check("leds", leds, 32'(1) << pos);
    check("go", go, m_armed());
    check("rndres", rndres, rnd);
    check("winner", winner, win);
    check("busy", busy, active);
  endtask

  initial begin
    bit r_, s_, l_, p_;
    int k;
    rst = 1; start = 0; lpush = 0; rpush = 0;
    active = 0; in_res = 0; pos = HALF; rnd = 0; win = 0; go_at = 0; res_end = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    // right player wins every round as soon as go is lit
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 2000 && win != 2; i++) cyc(0, 0, 0, m_armed());
    check("right_win", winner, 2'b10);
    repeat (20) cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    repeat (10) cyc(0, 1, 0, 0);
    // left push then reset in the middle of the result hold
    for (int i = 0; i < 200 && !in_res; i++) cyc(0, 0, m_armed(), 0);
    repeat (5) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 15000; i++) begin
      k  = $urandom_range(0, 99);
      r_ = $urandom_range(0, 2999) == 0;
      s_ = $urandom_range(0, active ? 49 : 7) == 0;
      if (m_armed()) begin
        l_ = k < 15;
        p_ = k >= 10 && k < 25;
      end else begin
        l_ = k < 2;
        p_ = k == 1 || k == 2;
      end
      cyc(r_, s_, l_, p_);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
